// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath swept over NUM_NEURONS stored states.
// Optional refractory counters are compiled in with `define LIF_REFRACTORY_EN.
module lif_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_W       = 2,
    parameter int THR_RESET   = 230,
    parameter int REFRAC      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   cur_ready,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic                   cur_valid,
    input  logic [7:0]             cur_data,
    input  logic                   thr_we,
    input  logic [7:0]             thr_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [7:0]             rd_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [7:0]                  cur_q, cur_d;
    logic [7:0]                  thr_q, thr_d;
    logic [NUM_NEURONS-1:0][7:0] mem_q, mem_d;
    logic [NUM_NEURONS-1:0]      spk_q, spk_d;

    logic [7:0] s_cur, c_eff, nxt_state;
    logic [9:0] sum;
    logic       fire;

    assign s_cur = mem_q[idx_q];
    assign fire  = (s_cur >= thr_q);

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
    logic [NUM_NEURONS-1:0][RW-1:0] ref_q, ref_d;
    logic                           refr;

    assign refr  = (ref_q[idx_q] != '0);
    assign c_eff = refr ? 8'd0 : cur_q;

    always_comb begin
        ref_d = ref_q;
        if (state_q == S_UPDATE) begin
            if (fire)      ref_d[idx_q] = RW'(REFRAC);
            else if (refr) ref_d[idx_q] = ref_q[idx_q] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_q <= '0;
        else        ref_q <= ref_d;
    end
`else
    localparam int unused_refrac = REFRAC;
    assign c_eff = cur_q;
`endif

    // Leak is s*(7/8) approximated by three shifts; 10 bits cannot overflow (max 476).
    assign sum       = {2'b00, c_eff} + {3'b000, s_cur[7:1]} + {4'b0000, s_cur[7:2]} + {5'b00000, s_cur[7:3]};
    assign nxt_state = fire ? 8'd0 : ((sum > 10'd255) ? 8'hFF : sum[7:0]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        thr_d   = thr_q;
        mem_d   = mem_q;
        spk_d   = spk_q;
        case (state_q)
            S_IDLE: begin
                if (thr_we) thr_d = thr_data;
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    spk_d   = '0;
                end
            end
            S_FETCH: begin
                if (cur_valid) begin
                    cur_d   = cur_data;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                mem_d[idx_q] = nxt_state;
                if (fire) spk_d[idx_q] = 1'b1;
                if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            thr_q   <= 8'(THR_RESET);
            mem_q   <= '0;
            spk_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            thr_q   <= thr_d;
            mem_q   <= mem_d;
            spk_q   <= spk_d;
        end
    end

    assign cur_ready = (state_q == S_FETCH);
    assign cur_idx   = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign spike_vec = spk_q;
    assign rd_state  = ({1'b0, rd_idx} < (IDX_W + 1)'(NUM_NEURONS)) ? mem_q[rd_idx] : 8'd0;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: latency, integration/saturation, backpressure, threshold and reset behaviour.
module tb_lif_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cur_ready;
    logic [1:0] cur_idx;
    logic       cur_valid = 1'b0;
    logic [7:0] cur_data = 8'd0;
    logic       thr_we = 1'b0;
    logic [7:0] thr_data = 8'd0;
    logic       busy, done;
    logic [3:0] spike_vec;
    logic [1:0] rd_idx = 2'd0;
    logic [7:0] rd_state;

    int nvec = 0;
    int nerr = 0;

    lif_scheduler #(.NUM_NEURONS(4), .IDX_W(2), .THR_RESET(230), .REFRAC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cur_ready(cur_ready), .cur_idx(cur_idx), .cur_valid(cur_valid), .cur_data(cur_data),
        .thr_we(thr_we), .thr_data(thr_data),
        .busy(busy), .done(done), .spike_vec(spike_vec),
        .rd_idx(rd_idx), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input int i, input int exp);
        rd_idx = 2'(i);
        #1;
        chk($sformatf("state%0d", i), int'(rd_state), exp);
    endtask

    // One timestep; cycle 1 is the first cycle after the accepting edge.
    task automatic run_ts(input logic [3:0][7:0] cur, input int stall_idx, input int stall_n,
                          input int start_at, input int thrwe_at,
                          output int done_cyc, output logic [15:0] seq);
        int cyc;
        int stalls;
        stalls = stall_n;
        seq    = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 1;
        while (!done && cyc < 60) begin
            if (cyc <= 8) seq = {seq[13:0], cur_idx};
            start    = (cyc == start_at);
            thr_we   = (cyc == thrwe_at);
            thr_data = 8'd50;
            if (cur_ready && int'(cur_idx) == stall_idx && stalls > 0) begin
                cur_valid = 1'b0;
                stalls--;
            end else begin
                cur_valid = 1'b1;
            end
            cur_data = cur[cur_idx];
            tick();
            cyc++;
        end
        start     = 1'b0;
        thr_we    = 1'b0;
        cur_valid = 1'b0;
        done_cyc  = done ? cyc : -1;
        tick();
        chk("done_pulse", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic ts(input logic [3:0][7:0] cur, input int exp_spk);
        int dc;
        logic [15:0] sq;
        run_ts(cur, -1, 0, -1, -1, dc, sq);
        chk("done_cyc", dc, 9);
        chk("spike_vec", int'(spike_vec), exp_spk);
    endtask

    initial begin
        int dc;
        logic [15:0] sq;

        repeat (2) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cur_ready), 0);
        chk("rst_idx", int'(cur_idx), 0);
        chk("rst_spk", int'(spike_vec), 0);
        for (int i = 0; i < 4; i++) chk_st(i, 0);
        #2 rst_n = 1'b1;
        tick();

        // Timestep 1: latency/index order, plus a threshold write while busy that must be dropped.
        run_ts({8'd0, 8'd0, 8'd0, 8'd100}, -1, 0, -1, 4, dc, sq);
        chk("lat_done", dc, 9);
        chk("lat_idxseq", int'(sq), 16'h05AF);
        chk("ts1_spk", int'(spike_vec), 0);
        chk_st(0, 100);
        for (int i = 1; i < 4; i++) chk_st(i, 0);

        ts({8'd0, 8'd0, 8'd0, 8'd100}, 0);
        chk_st(0, 187);

        // Backpressure at neuron 2 with a stray start mid-sweep.
        run_ts({8'd0, 8'd0, 8'd0, 8'd100}, 2, 3, 3, -1, dc, sq);
        chk("bp_done", dc, 12);
        chk("bp_idxseq", int'(sq), 16'b00_00_01_01_10_10_10_10);
        chk("ts3_spk", int'(spike_vec), 0);
        chk_st(0, 255);
        tick();
        chk("start_ignored", int'(busy), 0);

        ts({8'd0, 8'd0, 8'd0, 8'd100}, 4'b0001);
        for (int i = 0; i < 4; i++) chk_st(i, 0);

        ts('0, 0);
        ts('0, 0);

        thr_we = 1'b1; thr_data = 8'd50;
        tick();
        thr_we = 1'b0;
        ts({8'd0, 8'd0, 8'd0, 8'd60}, 0);
        chk_st(0, 60);
        ts('0, 4'b0001);
        chk_st(0, 0);
        ts('0, 0);
        ts('0, 0);

        ts({8'd30, 8'd20, 8'd70, 8'd60}, 0);
        chk_st(3, 30);

        // Abort a sweep while neuron 2 is in FETCH.
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!(cur_ready && cur_idx == 2'd2) && n < 20) begin
                cur_valid = 1'b1;
                cur_data  = 8'd0;
                tick();
                n++;
            end
            cur_valid = 1'b0;
            chk("abort_reached", n, 4);
        end
        chk("pre_rst_spk", int'(spike_vec), 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(cur_ready), 0);
        chk("abort_spk", int'(spike_vec), 0);
        for (int i = 0; i < 4; i++) chk_st(i, 0);
        tick();
        chk("abort_done2", int'(done), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_done", int'(done), 0);

        // Threshold is back at 230: a state of 60 must not fire.
        ts({8'd0, 8'd0, 8'd0, 8'd60}, 0);
        chk_st(0, 60);
        ts('0, 0);
        chk_st(0, 52);

`ifdef LIF_REFRACTORY_EN
        thr_we = 1'b1; thr_data = 8'd50;
        tick();
        thr_we = 1'b0;
        ts('0, 4'b0001);
        chk_st(0, 0);
        ts({8'd0, 8'd0, 8'd0, 8'd200}, 0);
        chk_st(0, 0);
        ts({8'd0, 8'd0, 8'd0, 8'd200}, 0);
        chk_st(0, 0);
        ts({8'd0, 8'd0, 8'd0, 8'd200}, 0);
        chk_st(0, 200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
